imu_spi_reader: RTL and testbench

- SPI master for the 3-axis accelerometer; the stage directly upstream of the raw-to-degree converter.
- Configures the sensor after reset, then burst-reads the six data registers at a fixed sample rate.
- Presents 10-bit two's-complement raw_x/raw_y/raw_z and a one-cycle data_valid strobe; data_valid is wired to the converter's update_output.

---
 rtl/imu_spi_reader_if.sv | 21 ++
 rtl/imu_spi_reader.sv | 249 ++++++++++++++++++++++++
 tb/tb_imu_spi_reader.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imu_spi_reader_if.sv
// SPI bus between the accelerometer reader (master) and the sensor (slave).
interface imu_spi_reader_if;
    logic spi_cs_n;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_cs_n,
        output spi_sclk,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_cs_n,
        input  spi_sclk,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/imu_spi_reader.sv
// SPI master (mode 3) for the 3-axis accelerometer: configures the sensor after reset, then
// burst-reads the six data registers once per SAMPLE_PERIOD and presents 10-bit samples.
module imu_spi_reader #(
    parameter int unsigned CLK_DIV       = 25,
    parameter int unsigned SAMPLE_PERIOD = 500000,
    parameter int unsigned STARTUP_WAIT  = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    imu_spi_reader_if.master spi,
    output logic [9:0]       raw_x,
    output logic [9:0]       raw_y,
    output logic [9:0]       raw_z,
    output logic             data_valid,
    output logic             busy
);

    typedef enum logic [2:0] {
        StStartup,
        StCfgFmt,
        StGap1,
        StCfgPwr,
        StWait,
        StRead,
        StLatch
    } state_e;

    typedef enum logic [1:0] {PhSetup, PhLow, PhHigh, PhHold} phase_e;

    localparam logic [7:0]  DivLast     = 8'(CLK_DIV - 1);
    localparam logic [31:0] StartupLast = 32'(STARTUP_WAIT - 1);
    localparam logic [31:0] GapLast     = 32'(2 * CLK_DIV - 1);
    localparam logic [31:0] PeriodLast  = 32'(SAMPLE_PERIOD - 1);
    // Frames are left-aligned; trailing ones keep MOSI high through read data bytes.
    localparam logic [55:0] TxCfgFmt    = {8'h31, 8'h00, 40'hFF_FFFF_FFFF};
    localparam logic [55:0] TxCfgPwr    = {8'h2D, 8'h08, 40'hFF_FFFF_FFFF};
    localparam logic [55:0] TxRead      = {8'hF2, 48'hFFFF_FFFF_FFFF};

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic [31:0] wait_q, wait_d;
    logic [31:0] period_q, period_d;
    logic [55:0] tx_q, tx_d;
    logic [47:0] rx_q, rx_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic [9:0]  raw_x_q, raw_x_d;
    logic [9:0]  raw_y_q, raw_y_d;
    logic [9:0]  raw_z_q, raw_z_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;

    logic        in_frame;
    logic        div_last;
    logic [5:0]  last_bit;
    logic        frame_done;
    logic        start_frame;
    logic [55:0] start_tx;

    assign in_frame = state_q inside {StCfgFmt, StCfgPwr, StRead};
    assign div_last = (div_q == DivLast);
    assign last_bit = (state_q == StRead) ? 6'd55 : 6'd15;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StStartup;
            phase_q  <= PhSetup;
            div_q    <= '0;
            bit_q    <= '0;
            wait_q   <= '0;
            period_q <= '0;
            tx_q     <= '1;
            rx_q     <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            mosi_q   <= 1'b1;
            raw_x_q  <= '0;
            raw_y_q  <= '0;
            raw_z_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            wait_q   <= wait_d;
            period_q <= period_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            raw_x_q  <= raw_x_d;
            raw_y_q  <= raw_y_d;
            raw_z_q  <= raw_z_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        div_d       = div_q;
        bit_d       = bit_q;
        wait_d      = wait_q;
        period_d    = period_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        raw_x_d     = raw_x_q;
        raw_y_d     = raw_y_q;
        raw_z_d     = raw_z_q;
        valid_d     = 1'b0;
        frame_done  = 1'b0;
        start_frame = 1'b0;
        start_tx    = TxRead;

        // Bit engine: setup, 2*CLK_DIV per bit (fall then rise), hold, then release cs_n.
        if (in_frame) begin
            unique case (phase_q)
                PhSetup: begin
                    if (div_last) begin
                        phase_d = PhLow;
                        div_d   = '0;
                        sclk_d  = 1'b0;
                        mosi_d  = tx_q[55];
                        tx_d    = {tx_q[54:0], 1'b1};
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                PhLow: begin
                    if (div_last) begin
                        phase_d = PhHigh;
                        div_d   = '0;
                        sclk_d  = 1'b1;
                        rx_d    = {rx_q[46:0], spi.spi_miso};
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                PhHigh: begin
                    if (div_last) begin
                        div_d = '0;
                        if (bit_q == last_bit) begin
                            phase_d = PhHold;
                        end else begin
                            phase_d = PhLow;
                            sclk_d  = 1'b0;
                            mosi_d  = tx_q[55];
                            tx_d    = {tx_q[54:0], 1'b1};
                            bit_d   = bit_q + 6'd1;
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                PhHold: begin
                    if (div_last) begin
                        div_d      = '0;
                        cs_n_d     = 1'b1;
                        mosi_d     = 1'b1;
                        frame_done = 1'b1;
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end

        // The sample period spans read start to read start, so it keeps running through READ.
        if (state_q inside {StWait, StRead, StLatch} && period_q != PeriodLast) begin
            period_d = period_q + 32'd1;
        end

        unique case (state_q)
            StStartup: begin
                if (wait_q == StartupLast) begin
                    wait_d      = '0;
                    state_d     = StCfgFmt;
                    start_frame = 1'b1;
                    start_tx    = TxCfgFmt;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            StCfgFmt: if (frame_done) state_d = StGap1;
            StGap1: begin
                if (wait_q == GapLast) begin
                    wait_d      = '0;
                    state_d     = StCfgPwr;
                    start_frame = 1'b1;
                    start_tx    = TxCfgPwr;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            StCfgPwr: if (frame_done) state_d = StWait;
            StWait: begin
                if (period_q == PeriodLast && enable) begin
                    state_d     = StRead;
                    period_d    = '0;
                    start_frame = 1'b1;
                    start_tx    = TxRead;
                end
            end
            StRead: begin
                if (frame_done) begin
                    state_d = StLatch;
                    raw_x_d = {rx_q[33:32], rx_q[47:40]};
                    raw_y_d = {rx_q[17:16], rx_q[31:24]};
                    raw_z_d = {rx_q[1:0], rx_q[15:8]};
                    valid_d = 1'b1;
                end
            end
            StLatch: state_d = StWait;
            default: state_d = StStartup;
        endcase

        if (start_frame) begin
            cs_n_d  = 1'b0;
            phase_d = PhSetup;
            div_d   = '0;
            bit_d   = '0;
            tx_d    = start_tx;
        end

        busy_d = ~cs_n_d;
    end

    assign spi.spi_cs_n = cs_n_q;
    assign spi.spi_sclk = sclk_q;
    assign spi.spi_mosi = mosi_q;
    assign raw_x        = raw_x_q;
    assign raw_y        = raw_y_q;
    assign raw_z        = raw_z_q;
    assign data_valid   = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_imu_spi_reader.sv
// Bench for imu_spi_reader: SPI slave model, frame and sample scoreboards,
// table-driven read vectors plus enable and mid-frame reset sequences.
module tb_imu_spi_reader;

    localparam int unsigned ClkDiv       = 2;
    localparam int unsigned StartupWait  = 10;
    localparam int unsigned SamplePeriod = 600;
    localparam logic [55:0] ReadFrame    = {8'hF2, 48'hFFFF_FFFF_FFFF};

    typedef struct {
        logic [47:0] miso;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [9:0]  z;
    } vec_t;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] z;
    } raw_t;

    typedef struct {
        int          nbits;
        logic [55:0] data;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [9:0] raw_x;
    logic [9:0] raw_y;
    logic [9:0] raw_z;
    logic       data_valid;
    logic       busy;

    imu_spi_reader_if bus ();

    imu_spi_reader #(
        .CLK_DIV      (ClkDiv),
        .SAMPLE_PERIOD(SamplePeriod),
        .STARTUP_WAIT (StartupWait)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .spi       (bus),
        .raw_x     (raw_x),
        .raw_y     (raw_y),
        .raw_z     (raw_z),
        .data_valid(data_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    raw_t   exp_raw_q[$];
    frame_t exp_frame_q[$];
    frame_t obs_frame_q[$];

    logic [47:0] miso_bytes = '0;
    logic [47:0] cur_miso = '0;
    logic [55:0] mosi_sh = '0;
    int          rise_cnt = 0;
    int          fall_cnt = 0;

    int          cyc = 0;
    int          fall_count = 0;
    int          dv_count = 0;
    int          last_fall_cyc = 0;
    int          last_rise_cyc = 0;
    int          last_dv_cyc = 0;
    logic        prev_cs = 1'b1;
    logic        prev_dv = 1'b0;
    logic        have_rise = 1'b0;
    logic        raw_unstable = 1'b0;
    logic [29:0] stable_raw = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // SPI slave, mode 3: drive MISO on falling SCLK, sample MOSI on rising SCLK.
    always @(negedge bus.spi_cs_n) begin
        rise_cnt = 0;
        fall_cnt = 0;
        mosi_sh  = '0;
        cur_miso = miso_bytes;
    end

    always @(negedge bus.spi_sclk) begin
        if (!bus.spi_cs_n) begin
            if (fall_cnt < 8) bus.spi_miso = 1'b1;
            else bus.spi_miso = cur_miso[6'(55 - fall_cnt)];
            fall_cnt++;
        end
    end

    always @(posedge bus.spi_sclk) begin
        if (!bus.spi_cs_n) begin
            mosi_sh = {mosi_sh[54:0], bus.spi_mosi};
            rise_cnt++;
        end
    end

    always @(posedge bus.spi_cs_n) begin
        if (!reset) obs_frame_q.push_back('{rise_cnt, mosi_sh});
    end

    always @(negedge clk) begin
        frame_t o;
        frame_t e;
        raw_t   r;
        cyc++;
        if (reset) begin
            prev_cs    = 1'b1;
            prev_dv    = 1'b0;
            have_rise  = 1'b0;
            stable_raw = '0;
        end else begin
            if (prev_cs && !bus.spi_cs_n) begin
                if (have_rise) check("cs_high_gap_ge4", 64'((cyc - last_rise_cyc) >= 4), 64'd1);
                fall_count++;
                last_fall_cyc = cyc;
            end
            if (!prev_cs && bus.spi_cs_n) begin
                have_rise     = 1'b1;
                last_rise_cyc = cyc;
            end
            while (obs_frame_q.size() > 0) begin
                o = obs_frame_q.pop_front();
                check("frame_expected", 64'(exp_frame_q.size() != 0), 64'd1);
                if (exp_frame_q.size() != 0) begin
                    e = exp_frame_q.pop_front();
                    check("frame_sclk_rises", 64'(o.nbits), 64'(e.nbits));
                    check("frame_mosi", 64'(o.data), 64'(e.data));
                end
            end
            if (data_valid) begin
                check("dv_one_cycle", 64'(prev_dv), 64'd0);
                check("sample_expected", 64'(exp_raw_q.size() != 0), 64'd1);
                if (exp_raw_q.size() != 0) begin
                    r = exp_raw_q.pop_front();
                    check("raw_x", 64'(raw_x), 64'(r.x));
                    check("raw_y", 64'(raw_y), 64'(r.y));
                    check("raw_z", 64'(raw_z), 64'(r.z));
                end
                dv_count++;
                last_dv_cyc = cyc;
                stable_raw  = {raw_x, raw_y, raw_z};
            end else if ({raw_x, raw_y, raw_z} != stable_raw) begin
                raw_unstable = 1'b1;
            end
            prev_cs = bus.spi_cs_n;
            prev_dv = data_valid;
        end
    end

    task automatic push_read(input vec_t v);
        miso_bytes = v.miso;
        exp_frame_q.push_back('{56, ReadFrame});
        exp_raw_q.push_back('{v.x, v.y, v.z});
    endtask

    task automatic expect_config();
        exp_frame_q.push_back('{16, 56'h3100});
        exp_frame_q.push_back('{16, 56'h2D08});
    endtask

    task automatic wait_dv(input string name, input int budget);
        int  start;
        logic seen;
        start = dv_count;
        seen  = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (dv_count != start) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 64'(seen), 64'd1);
    endtask

    task automatic wait_cs_low(input string name, input int budget);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!bus.spi_cs_n) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 64'(seen), 64'd1);
    endtask

    // Called right after reset is released at a falling clk edge.
    task automatic count_to_cs(input string name);
        int n;
        n = 51;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk);
            #1;
            if (!bus.spi_cs_n) begin
                n = k;
                break;
            end
        end
        check(name, 64'(n), 64'(StartupWait));
    endtask

    initial begin
        vec_t        vecs[8];
        logic [47:0] abort_miso;
        logic        found;
        int          pf;
        int          pd;
        int          f0;
        int          d0;

        vecs[0] = '{48'h34_01_F0_03_00_02, 10'h134, 10'h3F0, 10'h200};
        vecs[1] = '{48'hFF_FF_FF_FF_FF_FF, 10'h3FF, 10'h3FF, 10'h3FF};
        vecs[2] = '{48'h00_00_00_00_00_00, 10'h000, 10'h000, 10'h000};
        vecs[3] = '{48'hAA_FD_55_02_01_FE, 10'h1AA, 10'h255, 10'h201};
        vecs[4] = '{48'h00_02_FF_01_80_00, 10'h200, 10'h1FF, 10'h080};
        vecs[5] = '{48'h12_02_34_01_56_03, 10'h212, 10'h134, 10'h356};
        vecs[6] = '{48'h7F_00_80_03_C3_01, 10'h07F, 10'h380, 10'h1C3};
        vecs[7] = '{48'hEE_FE_DD_FD_CC_FC, 10'h2EE, 10'h1DD, 10'h0CC};
        abort_miso = 48'h11_11_11_11_11_11;

        reset  = 1'b1;
        enable = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", 64'(bus.spi_cs_n), 64'd1);
        check("rst_sclk", 64'(bus.spi_sclk), 64'd1);
        check("rst_mosi", 64'(bus.spi_mosi), 64'd1);
        check("rst_raw_x", 64'(raw_x), 64'd0);
        check("rst_raw_y", 64'(raw_y), 64'd0);
        check("rst_raw_z", 64'(raw_z), 64'd0);
        check("rst_data_valid", 64'(data_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        expect_config();
        push_read(vecs[0]);
        reset = 1'b0;
        count_to_cs("startup_cycles");

        pf = 0;
        pd = 0;
        for (int i = 0; i < 5; i++) begin
            wait_dv("dv_vector", 1500);
            if (i > 0) begin
                check("cs_fall_period", 64'(last_fall_cyc - pf), 64'(SamplePeriod));
                check("dv_period", 64'(last_dv_cyc - pd), 64'(SamplePeriod));
            end
            pf = last_fall_cyc;
            pd = last_dv_cyc;
            if (i < 4) push_read(vecs[i+1]);
        end

        // Dropping enable mid-read lets the burst finish, then reads stop.
        push_read(vecs[5]);
        f0 = fall_count;
        d0 = dv_count;
        wait_cs_low("read_start", 1000);
        repeat (30) @(negedge clk);
        enable = 1'b0;
        wait_dv("dv_after_enable_drop", 1000);
        repeat (2000) @(negedge clk);
        check("frames_since_drop", 64'(fall_count - f0), 64'd1);
        check("dv_since_drop", 64'(dv_count - d0), 64'd1);

        push_read(vecs[6]);
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("start_on_enable_cs_n", 64'(bus.spi_cs_n), 64'd0);
        check("start_on_enable_busy", 64'(busy), 64'd1);
        wait_dv("dv_after_enable_rise", 1000);

        // Reset while bit 20 of a read frame has SCLK low.
        miso_bytes = abort_miso;
        found      = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if (!bus.spi_cs_n && !bus.spi_sclk && rise_cnt == 20) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_bit20", 64'(found), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_cs_n", 64'(bus.spi_cs_n), 64'd1);
        check("abort_sclk", 64'(bus.spi_sclk), 64'd1);
        check("abort_raw_x", 64'(raw_x), 64'd0);
        check("abort_raw_y", 64'(raw_y), 64'd0);
        check("abort_raw_z", 64'(raw_z), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        expect_config();
        push_read(vecs[7]);
        reset = 1'b0;
        count_to_cs("restart_startup_cycles");
        wait_dv("dv_after_reset", 1500);

        check("raw_stable_between_dv", 64'(raw_unstable), 64'd0);
        check("frames_left", 64'(exp_frame_q.size()), 64'd0);
        check("samples_left", 64'(exp_raw_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
